// File: rtl/fir_inv_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fir_inv_pkg
// Brief   : Shared constants, coefficient table and state encoding for the
//           recursive FIR deconvolver.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
package fir_inv_pkg;

  localparam int ACC_W_DEF = 20;

  // FIR coefficients h[k] = k+1; h[0] = 1 removes the need for a divider
  localparam logic [3:0] FIR_H [0:7] = '{4'd1, 4'd2, 4'd3, 4'd4,
                                         4'd5, 4'd6, 4'd7, 4'd8};

  localparam int X_MAX = 127;
  localparam int X_MIN = -128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fir_inv_mac.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fir_inv_mac
// Brief   : Combinational multiply-subtract acc - h*x used once per MAC cycle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module fir_inv_mac #(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic        [3:0]       i_h,
  input  logic signed [7:0]       i_x,
  output logic signed [ACC_W-1:0] o_diff
);

  logic signed [12:0] w_prod;

  // coefficient is unsigned 4-bit, zero-extended to stay positive in signed math
  assign w_prod = $signed({1'b0, i_h}) * i_x;
  assign o_diff = i_acc - {{(ACC_W-13){w_prod[12]}}, w_prod};

endmodule
`default_nettype wire

// File: rtl/fir_inverse.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : fir_inverse
// Brief   : Time-multiplexed recursive deconvolver for the 4-tap FIR
//           (x[n] = y[n] - sum h[k]*x[n-k]); optional output clamp via
//           FIR_INV_SAT_EN, otherwise two's-complement wrap.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module fir_inverse
  import fir_inv_pkg::*;
#(
  parameter int N     = 4,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] y_in,
  input  logic        y_valid,
  output logic        y_ready,
  input  logic        clear_hist,
  output logic [7:0]  x_out,
  output logic        x_valid,
  input  logic        x_ready,
  output logic        sat_out
);

  localparam logic [2:0] C_K_LAST = 3'(N-1);

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [2:0]        r_k;
  logic signed [7:0]        r_hist [1:N-1];
  logic        [7:0]        r_x_out;
  logic                     r_x_valid;
  logic                     r_sat;

  logic signed [ACC_W-1:0]  w_mac;
  logic signed [7:0]        w_xh;
  logic        [3:0]        w_h;
  logic        [7:0]        w_x_narrow;
  logic                     w_sat;
  logic                     w_accept;

  assign y_ready  = reset_n && (r_state == IDLE) && !clear_hist;
  assign w_accept = y_valid && y_ready;
  assign x_out    = r_x_out;
  assign x_valid  = r_x_valid;
  assign sat_out  = r_sat;

  assign w_h = FIR_H[r_k];

  always_comb begin
    w_xh = '0;
    for (int i = 1; i < N; i++) begin
      if (r_k == 3'(i)) w_xh = r_hist[i];
    end
  end

  fir_inv_mac #(
    .ACC_W (ACC_W)
  ) u_mac (
    .i_acc  (r_acc),
    .i_h    (w_h),
    .i_x    (w_xh),
    .o_diff (w_mac)
  );

`ifdef FIR_INV_SAT_EN
  always_comb begin
    w_x_narrow = r_acc[7:0];
    w_sat      = 1'b0;
    if (r_acc > ACC_W'(X_MAX)) begin
      w_x_narrow = 8'(X_MAX);
      w_sat      = 1'b1;
    end else if (r_acc < ACC_W'(X_MIN)) begin
      w_x_narrow = 8'(X_MIN);
      w_sat      = 1'b1;
    end
  end
`else
  logic w_unused;
  assign w_x_narrow = r_acc[7:0];
  assign w_sat      = 1'b0;
  assign w_unused   = ^r_acc[ACC_W-1:8];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_k       <= '0;
      r_x_out   <= '0;
      r_x_valid <= 1'b0;
      r_sat     <= 1'b0;
      for (int i = 1; i < N; i++) r_hist[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_hist) begin
            for (int i = 1; i < N; i++) r_hist[i] <= '0;
          end else if (w_accept) begin
            r_acc   <= {{(ACC_W-16){y_in[15]}}, y_in};
            r_k     <= 3'd1;
            r_state <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_mac;
          r_k   <= r_k + 3'd1;
          if (r_k == C_K_LAST) r_state <= OUT;
        end
        OUT: begin
          // first OUT cycle captures the result; afterwards hold until taken
          if (!r_x_valid) begin
            r_x_out   <= w_x_narrow;
            r_sat     <= w_sat;
            r_x_valid <= 1'b1;
          end else if (x_ready) begin
            for (int i = N-1; i >= 2; i--) r_hist[i] <= r_hist[i-1];
            r_hist[1] <= $signed(r_x_out);
            r_x_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_inverse.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_fir_inverse
// Brief   : Directed + random bench for fir_inverse against an arithmetic model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fir_inverse;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] y_in = '0;
  logic        y_valid = 1'b0;
  logic        clear_hist = 1'b0;
  logic        x_ready = 1'b0;
  logic        y_ready;
  logic [7:0]  x_out;
  logic        x_valid;
  logic        sat_out;

  int total = 0;
  int bad   = 0;
  int mh [1:7];
  int imp [6] = '{1, 2, 3, 4, 0, 0};
  int rt  [3] = '{5, 7, 16};

  fir_inverse #(.N(N), .ACC_W(20)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .y_in       (y_in),
    .y_valid    (y_valid),
    .y_ready    (y_ready),
    .clear_hist (clear_hist),
    .x_out      (x_out),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .sat_out    (sat_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int k = 1; k <= 7; k++) mh[k] = 0;
  endfunction

  // x = y - sum h[k]*x[n-k], then narrow; history keeps the narrowed value
  task automatic model_step(input int y, output int x, output int s);
    int acc;
    acc = y;
    for (int k = 1; k < N; k++) acc -= (k + 1) * mh[k];
`ifdef FIR_INV_SAT_EN
    if (acc > 127) begin x = 127; s = 1; end
    else if (acc < -128) begin x = -128; s = 1; end
    else begin x = acc; s = 0; end
`else
    x = acc & 255;
    if (x > 127) x -= 256;
    s = 0;
`endif
    for (int k = N - 1; k >= 2; k--) mh[k] = mh[k-1];
    mh[1] = x;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_y_ready", int'(y_ready), 0);
    check("rst_x_valid", int'(x_valid), 0);
    check("rst_x_out", int'(x_out), 0);
    check("rst_sat_out", int'(sat_out), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  task automatic send(input int y, input int stall);
    int xe, se, lat, waitc;
    model_step(y, xe, se);
    x_ready = (stall == 0);
    @(negedge clk);
    y_in = 16'(y);
    y_valid = 1'b1;
    waitc = 0;
    while (!y_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("accept_wait", int'(waitc < 50), 1);
    @(posedge clk);
    #1 y_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!x_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N);
    check("x_out", int'($signed(x_out)), xe);
    check("sat_out", int'(sat_out), se);
    for (int s = 0; s < stall; s++) begin
      check("bp_y_ready", int'(y_ready), 0);
      check("bp_x_valid", int'(x_valid), 1);
      check("bp_x_out", int'($signed(x_out)), xe);
      @(negedge clk);
    end
    x_ready = 1'b1;
    @(negedge clk);
    check("xfer_x_valid", int'(x_valid), 0);
    check("xfer_y_ready", int'(y_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, y, xv;
    int xs[$];
    model_clear();
    do_reset();

    foreach (imp[i]) send(imp[i], 0);
    foreach (rt[i]) send(rt[i], 0);

    do_reset();
    send(200, 0);

    do_reset();
    send(9, 5);

    do_reset();
    send(1, 0);
    send(2, 0);
    // clear together with a valid sample: clear must win
    @(negedge clk);
    clear_hist = 1'b1;
    y_valid = 1'b1;
    y_in = 16'd2;
    #1 check("ready_during_clear", int'(y_ready), 0);
    @(posedge clk);
    #1;
    clear_hist = 1'b0;
    y_valid = 1'b0;
    @(negedge clk);
    check("ready_after_clear", int'(y_ready), 1);
    check("no_accept_on_clear", int'(x_valid), 0);
    model_clear();
    send(2, 0);

    // reset during the second MAC cycle discards the sample
    @(negedge clk);
    y_in = 16'd50;
    y_valid = 1'b1;
    check("ready_before_mac", int'(y_ready), 1);
    @(posedge clk);
    #1 y_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midmac_x_valid", int'(x_valid), 0);
    check("midmac_y_ready", int'(y_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_clear();
    seen = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (x_valid) seen++;
    end
    check("no_x_after_reset", seen, 0);
    send(9, 0);

    // random source stream through the forward FIR, then deconvolved
    do_reset();
    for (int n = 0; n < 10; n++) begin
      xv = int'($urandom_range(60)) - 30;
      xs.push_front(xv);
      y = 0;
      for (int k = 0; k < N; k++) begin
        if (k < xs.size()) y += (k + 1) * xs[k];
      end
      send(y, int'($urandom_range(2)));
    end

    // arbitrary input samples, exercising the narrowing path
    for (int n = 0; n < 12; n++) begin
      y = int'($urandom_range(1200)) - 600;
      send(y, int'($urandom_range(2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
